dmem_responder: RTL and testbench

Data-memory responder on the far end of the CPU load/store port. It accepts one word-wide request at a time from the MIPS core over a req/ack handshake, inserts a programmable number of wait states, then commits the write or returns read data with a one-cycle acknowledge. It sits beside the core as the multi-cycle replacement for the combinational data memory, and reports misaligned and out-of-range accesses.

---
 rtl/mips_bus_pkg.sv | 25 ++
 rtl/dmem_responder_if.sv | 30 +++
 rtl/dmem_array.sv | 44 ++++
 rtl/dmem_responder.sv | 149 ++++++++++++++
 tb/tb_dmem_responder.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips_bus_pkg                                                               |
// | Shared types, widths and the access-fault helper for the data-memory port. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mips_bus_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Misaligned or beyond the last stored word; upper address bits only matter here.
  function automatic logic addr_fault(input logic [WORD_W-1:0] addr,
                                      input logic [WORD_W-1:0] depth_words);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[WORD_W-1:2]} >= depth_words);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_responder_if                                                          |
// | Load/store request/acknowledge bus between the core and the responder.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface dmem_responder_if;
  import mips_bus_pkg::*;

  logic              req;
  logic              we;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic [BE_W-1:0]   be;
  logic              ack;
  logic [WORD_W-1:0] rdata;
  logic              err;

  modport master (
    output req, we, addr, wdata, be,
    input  ack, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ack, rdata, err
  );

endinterface
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_array                                                                 |
// | Word-wide storage with byte-enable synchronous write and synchronous read. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dmem_array
  import mips_bus_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  wire logic                           clk,
  input  wire logic                           i_wr_en,
  input  wire logic                           i_rd_en,
  input  wire logic [$clog2(DEPTH_WORDS)-1:0] i_idx,
  input  wire logic [BE_W-1:0]                i_be,
  input  wire logic [WORD_W-1:0]              i_wdata,
  output logic      [WORD_W-1:0]              o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
  logic [WORD_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (i_be[b]) begin
          r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read port only updates on a load commit, so the word holds until the next load.
  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      r_q <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_q;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_responder                                                             |
// | Multi-cycle data-memory responder: wait states, fault check, one-cycle ack.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dmem_responder
  import mips_bus_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  wire logic        clk,
  input  wire logic        rst,
  dmem_responder_if.slave  bus
);

  localparam int                c_aw    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]        c_wait  = 4'(WAIT_CYCLES);
  localparam logic [WORD_W-1:0] c_depth = WORD_W'(DEPTH_WORDS);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;

  logic              r_we;
  logic [WORD_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;

  logic              r_ack;
  logic              r_err;
  logic              r_rd_sel;

  logic              w_latch;
  logic              w_commit;
  logic              w_op_we;
  logic [WORD_W-1:0] w_op_addr;
  logic [WORD_W-1:0] w_op_wdata;
  logic [BE_W-1:0]   w_op_be;
  logic              w_fault;
  logic              w_mem_wr;
  logic              w_mem_rd;
  logic [WORD_W-1:0] w_mem_q;

  // With no wait states the capture edge is also the commit edge, so live inputs are used.
  always_comb begin
    w_op_we    = r_we;
    w_op_addr  = r_addr;
    w_op_wdata = r_wdata;
    w_op_be    = r_be;
    if (r_state == IDLE) begin
      w_op_we    = bus.we;
      w_op_addr  = bus.addr;
      w_op_wdata = bus.wdata;
      w_op_be    = bus.be;
    end
  end

  assign w_fault = addr_fault(w_op_addr, c_depth);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req) begin
          w_latch = 1'b1;
          if (c_wait == 4'd0) begin
            w_state_nxt = RESP;
            w_commit    = 1'b1;
          end else begin
            w_state_nxt = BUSY;
            w_cnt_nxt   = c_wait;
          end
        end
      end
      BUSY: begin
        if (r_cnt == 4'd1) begin
          w_state_nxt = RESP;
          w_cnt_nxt   = 4'd0;
          w_commit    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_rd_sel <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_latch) begin
        r_we    <= bus.we;
        r_addr  <= bus.addr;
        r_wdata <= bus.wdata;
        r_be    <= bus.be;
      end
      r_ack <= w_commit;
      r_err <= w_commit & w_fault;
      if (w_commit) begin
        r_rd_sel <= ~w_op_we & ~w_fault;
      end
    end
  end

  // The array has no reset, so its enables are gated to keep reset from committing anything.
  assign w_mem_wr = w_commit &  w_op_we & ~w_fault & rst;
  assign w_mem_rd = w_commit & ~w_op_we & ~w_fault & rst;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .i_wr_en (w_mem_wr),
    .i_rd_en (w_mem_rd),
    .i_idx   (w_op_addr[c_aw+1:2]),
    .i_be    (w_op_be),
    .i_wdata (w_op_wdata),
    .o_rdata (w_mem_q)
  );

  assign bus.ack   = r_ack;
  assign bus.err   = r_err;
  assign bus.rdata = r_rd_sel ? w_mem_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dmem_responder                                                          |
// | Directed bench for two responders (0 and 2 wait states) with a word model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dmem_responder;

  typedef struct {
    int          due;
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  ent_t        q0[$];
  ent_t        q1[$];
  logic [31:0] mm [bit [32:0]];
  logic [31:0] last_rd_m [2];
  int          free_e [2];

  int          last_cap;
  int          last_ack;
  logic [31:0] last_rd;
  logic        last_err;

  dmem_responder_if bus0 ();
  dmem_responder_if bus2 ();

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );
  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut2 (
    .clk (clk), .rst (rst), .bus (bus2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wait_of(input int sel);
    return (sel == 0) ? 0 : 2;
  endfunction

  function automatic logic get_ack(input int sel);
    return (sel == 0) ? bus0.ack : bus2.ack;
  endfunction

  function automatic logic [31:0] get_rdata(input int sel);
    return (sel == 0) ? bus0.rdata : bus2.rdata;
  endfunction

  function automatic logic get_err(input int sel);
    return (sel == 0) ? bus0.err : bus2.err;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive(input int sel, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    if (sel == 0) begin
      bus0.req = r; bus0.we = w; bus0.addr = a; bus0.wdata = d; bus0.be = b;
    end else begin
      bus2.req = r; bus2.we = w; bus2.addr = a; bus2.wdata = d; bus2.be = b;
    end
  endtask

  task automatic flush();
    q0.delete();
    q1.delete();
    last_rd_m[0] = 32'h0;
    last_rd_m[1] = 32'h0;
    free_e[0] = 0;
    free_e[1] = 0;
  endtask

  // Reference: a transaction resolves at its due edge against the word model.
  task automatic cmp(input int sel, input logic ack, input logic [31:0] rd, input logic er);
    ent_t        e;
    bit          has;
    bit          flt;
    bit [32:0]   k;
    logic [31:0] old;
    logic [31:0] erd;
    logic        eer;
    has = 1'b0;
    if (rst) begin
      if (sel == 0 && q0.size() > 0 && q0[0].due == cyc) begin
        has = 1'b1; e = q0.pop_front();
      end else if (sel == 1 && q1.size() > 0 && q1[0].due == cyc) begin
        has = 1'b1; e = q1.pop_front();
      end
    end
    erd = (rst) ? last_rd_m[sel] : 32'h0;
    eer = 1'b0;
    if (has) begin
      flt = (e.a[1:0] != 2'b00) || (e.a[31:2] >= 30'd1024);
      erd = 32'h0;
      eer = flt;
      if (!flt) begin
        k   = {(sel != 0), 2'b00, e.a[31:2]};
        old = mm.exists(k) ? mm[k] : 32'h0;
        if (e.w) begin
          for (int i = 0; i < 4; i++) begin
            if (e.b[i]) old[i*8 +: 8] = e.d[i*8 +: 8];
          end
          mm[k] = old;
        end else begin
          erd = old;
        end
      end
      last_rd_m[sel] = erd;
    end
    chk($sformatf("ack_dut%0d", sel), {31'h0, ack}, {31'h0, has});
    chk($sformatf("rdata_dut%0d", sel), rd, erd);
    chk($sformatf("err_dut%0d", sel), {31'h0, er}, {31'h0, eer});
  endtask

  always @(negedge clk) begin
    cmp(0, bus0.ack, bus0.rdata, bus0.err);
    cmp(1, bus2.ack, bus2.rdata, bus2.err);
  end

  task automatic txn(input int sel, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, input bit scramble, input bit keep, input bit abort);
    int   cap;
    int   n;
    ent_t e;
    drive(sel, 1'b1, w, a, d, b);
    cap   = (cyc + 1 > free_e[sel]) ? cyc + 1 : free_e[sel];
    e.due = cap + wait_of(sel);
    e.w = w; e.a = a; e.d = d; e.b = b;
    if (sel == 0) q0.push_back(e); else q1.push_back(e);
    free_e[sel] = e.due + 2;
    last_cap = cap;
    while (cyc < cap) begin
      @(posedge clk); #1;
    end
    if (scramble) drive(sel, 1'b1, w, a ^ 32'h4, ~d, b);
    if (abort) begin
      @(posedge clk); #1;
      rst = 1'b0;
      drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      flush();
      #1 chk("abort_ack_low", {31'h0, get_ack(sel)}, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
    end else begin
      n = 0;
      while (!get_ack(sel) && n < 40) begin
        @(posedge clk); #1; n++;
      end
      chk("ack_seen", {31'h0, get_ack(sel)}, 32'h1);
      last_ack = cyc;
      last_rd  = get_rdata(sel);
      last_err = get_err(sel);
      if (!keep) drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    end
  endtask

  int a1, a2, a3;

  initial begin
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    flush();
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", {31'h0, get_ack(1)}, 32'h0);
    chk("reset_rdata", get_rdata(1), 32'h0);
    chk("reset_err", {31'h0, get_err(1)}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Full-word store, two wait states, then read back.
    txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 1'b0);
    chk("store_latency", 32'(last_ack - last_cap), 32'd2);
    chk("store_err", {31'h0, last_err}, 32'h0);
    txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("load_0x10", last_rd, 32'hDEADBEEF);

    // Byte-enable merge.
    txn(1, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, 1'b0, 1'b0);
    txn(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b0, 1'b0);
    txn(1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0);
    chk("load_merge", last_rd, 32'h11BB33DD);

    // Faults: misaligned, out of range, aliasing store, misaligned store.
    txn(1, 1'b0, 32'h22, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0);
    chk("misalign_err", {31'h0, last_err}, 32'h1);
    chk("misalign_rdata", last_rd, 32'h0);
    txn(1, 1'b0, 32'h1000, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0);
    chk("range_err", {31'h0, last_err}, 32'h1);
    chk("range_rdata", last_rd, 32'h0);
    txn(1, 1'b1, 32'h1020, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b0, 1'b0);
    chk("range_store_err", {31'h0, last_err}, 32'h1);
    txn(1, 1'b1, 32'h21, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b0, 1'b0);
    chk("misalign_store_err", {31'h0, last_err}, 32'h1);
    txn(1, 1'b1, 32'h20, 32'h00000000, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("be0_err", {31'h0, last_err}, 32'h0);
    txn(1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0);
    chk("load_unchanged", last_rd, 32'h11BB33DD);

    // Zero wait states, back-to-back with req held high.
    txn(0, 1'b1, 32'h40, 32'h01010101, 4'hF, 1'b0, 1'b1, 1'b0);
    chk("w0_latency", 32'(last_ack - last_cap), 32'd0);
    txn(0, 1'b1, 32'h44, 32'h02020202, 4'hF, 1'b0, 1'b1, 1'b0);
    txn(0, 1'b1, 32'h48, 32'h03030303, 4'hF, 1'b0, 1'b1, 1'b0);
    txn(0, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    a1 = last_ack;
    chk("w0_load0", last_rd, 32'h01010101);
    txn(0, 1'b0, 32'h44, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    a2 = last_ack;
    chk("w0_load1", last_rd, 32'h02020202);
    txn(0, 1'b0, 32'h48, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    a3 = last_ack;
    chk("w0_load2", last_rd, 32'h03030303);
    chk("w0_spacing1", 32'(a2 - a1), 32'd2);
    chk("w0_spacing2", 32'(a3 - a2), 32'd2);

    // Reset during the wait states of a store.
    txn(1, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, 1'b0);
    txn(1, 1'b1, 32'h30, 32'h12345678, 4'hF, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    txn(1, 1'b0, 32'h30, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0);
    chk("abort_kept", last_rd, 32'hCAFEF00D);

    // Operands changed while busy must not leak into the transaction.
    txn(1, 1'b1, 32'h54, 32'h54545454, 4'hF, 1'b0, 1'b0, 1'b0);
    txn(1, 1'b1, 32'h50, 32'h55AA55AA, 4'hF, 1'b1, 1'b0, 1'b0);
    txn(1, 1'b0, 32'h50, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0);
    chk("latched_0x50", last_rd, 32'h55AA55AA);
    txn(1, 1'b0, 32'h54, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0);
    chk("latched_0x54", last_rd, 32'h54545454);

    repeat (4) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
